// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter paced by the br_tick pulse from baudrate_gen.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after the data bits.
module uart_tx #(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int TICKS_PER_BIT = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        TICKS_PER_BIT < 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx: unsupported parameter set");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, STOP} state_t;
`endif

    state_t                 r_state;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [TW-1:0]          r_tick_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic                   r_stop_cnt;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;
`ifdef UART_TX_PARITY_EN
    logic                   r_par;
`endif
    logic                   w_bit_end;
    logic                   w_in_bit;

    assign w_bit_end = br_tick && (r_tick_cnt == TICK_LAST);
    assign w_in_bit  = (r_state != IDLE) && (r_state != ALIGN);

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (br_tick && w_in_bit)
                r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
            unique case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_start) begin
                        r_shreg <= tx_data;
                        r_busy  <= 1'b1;
                        r_state <= ALIGN;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^tx_data ^ PARITY_ODD[0];
`endif
                    end
                end
                // first tick after accept opens the start bit on a tick boundary
                ALIGN: if (br_tick) begin
                    r_state <= START;
                    r_tx    <= 1'b0;
                end
                START: if (w_bit_end) begin
                    r_state <= DATA;
                    r_tx    <= r_shreg[0];
                end
                DATA: if (w_bit_end) begin
                    r_shreg <= r_shreg >> 1;
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        r_state   <= PARITY;
                        r_tx      <= r_par;
`else
                        r_state   <= STOP;
                        r_tx      <= 1'b1;
`endif
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_tx      <= r_shreg[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (w_bit_end) begin
                    r_state <= STOP;
                    r_tx    <= 1'b1;
                end
`endif
                STOP: if (w_bit_end) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        r_stop_cnt <= 1'b0;
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
